// File: rtl/sdram_ctrl_fsm.sv
// Single-rank SDR SDRAM controller: power-up/init sequence, periodic auto-refresh,
// one burst read or write per request with auto-precharge. All SDRAM pins are registered.
module sdram_ctrl_fsm #(
    parameter int PWRUP_p    = 100,
    parameter int RP_p       = 2,
    parameter int RFC_p      = 7,
    parameter int MRD_p      = 2,
    parameter int RCD_p      = 2,
    parameter int WR_p       = 2,
    parameter int CAS_p      = 2,
    parameter int BURST_p    = 4,
    parameter int REF_INT_p  = 1040,
    parameter int INIT_REF_p = 2,
    parameter int ROW_W_p    = 13,
    parameter int COL_W_p    = 9,
    parameter int BANK_W_p   = 2,
    parameter int DATA_W_p   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [BANK_W_p+ROW_W_p+COL_W_p-1:0]   req_addr_i,
    input  logic [DATA_W_p-1:0]                   wr_data_i,
    output logic                                  wr_take_o,
    output logic [DATA_W_p-1:0]                   rd_data_o,
    output logic                                  rd_valid_o,
    output logic                                  init_done_o,
    output logic                                  cs_n_o,
    output logic                                  ras_n_o,
    output logic                                  cas_n_o,
    output logic                                  we_n_o,
    output logic                                  cke_o,
    output logic [BANK_W_p-1:0]                   ba_o,
    output logic [ROW_W_p-1:0]                    a_o,
    output logic [DATA_W_p-1:0]                   dq_o,
    output logic                                  dq_oe_o,
    input  logic [DATA_W_p-1:0]                   dq_i
);

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int ADDR_W  = BANK_W_p + ROW_W_p + COL_W_p;
    localparam int CNT_MAX = max2(max2(max2(PWRUP_p, RFC_p), max2(RP_p, MRD_p)),
                                  max2(max2(RCD_p, WR_p + RP_p), CAS_p + BURST_p));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = (REF_INT_p > 1) ? $clog2(REF_INT_p) : 1;
    localparam int IREF_W  = $clog2(INIT_REF_p + 1);
    localparam int BCNT_W  = (BURST_p > 1) ? $clog2(BURST_p) : 1;
    localparam int BL_CODE = (BURST_p == 8) ? 3 : (BURST_p == 4) ? 2 : (BURST_p == 2) ? 1 : 0;

    localparam logic [ROW_W_p-1:0] A10   = ROW_W_p'(1 << 10);
    // {write burst = programmed, op mode 0, CAS latency, sequential, burst length}
    localparam logic [ROW_W_p-1:0] MRS_A = ROW_W_p'(CAS_p * 16 + BL_CODE);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;

    typedef enum logic [3:0] {
        PWRUP, INIT_PC, INIT_REF, INIT_MRS, IDLE,
        REFRESH, ACTIVATE, RDCMD, WRCMD, RECOVER
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_dec;
    logic [IREF_W-1:0]     iref_q, iref_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [COL_W_p-1:0]    col_q, col_d;
    logic                  we_q, we_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [BANK_W_p-1:0]   ba_q, ba_d;
    logic [ROW_W_p-1:0]    a_q, a_d;
    logic [DATA_W_p-1:0]   dq_q, dq_d;
    logic                  dq_oe_q, dq_oe_d;
    logic [DATA_W_p-1:0]   rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  init_done_q, init_done_d;
    logic                  cke_q;
    logic                  ref_pending_q;
    logic [TMR_W-1:0]      tmr_q;
    logic                  ref_clr, wr_take;

    assign cnt_dec = cnt_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iref_d      = iref_q;
        bcnt_d      = bcnt_q;
        col_d       = col_q;
        we_d        = we_q;
        cmd_d       = CMD_NOP;
        ba_d        = ba_q;
        a_d         = a_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        init_done_d = init_done_q;
        ref_clr     = 1'b0;
        wr_take     = 1'b0;
        case (state_q)
            // The counter is cleared by reset, so power-up counts up to PWRUP_p.
            PWRUP: begin
                if (cnt_q == CNT_W'(PWRUP_p)) begin
                    state_d = INIT_PC;
                    cmd_d   = CMD_PRE;
                    a_d     = A10;
                    cnt_d   = CNT_W'(RP_p - 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INIT_PC: begin
                if (cnt_q == '0) begin
                    state_d = INIT_REF;
                    cmd_d   = CMD_REF;
                    iref_d  = IREF_W'(1);
                    cnt_d   = CNT_W'(RFC_p - 1);
                end else cnt_d = cnt_dec;
            end
            INIT_REF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                end else if (iref_q == IREF_W'(INIT_REF_p)) begin
                    state_d = INIT_MRS;
                    cmd_d   = CMD_MRS;
                    ba_d    = '0;
                    a_d     = MRS_A;
                    cnt_d   = CNT_W'(MRD_p - 1);
                end else begin
                    cmd_d  = CMD_REF;
                    iref_d = iref_q + IREF_W'(1);
                    cnt_d  = CNT_W'(RFC_p - 1);
                end
            end
            INIT_MRS: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else cnt_d = cnt_dec;
            end
            IDLE: begin
                if (ref_pending_q) begin
                    state_d = REFRESH;
                    cmd_d   = CMD_REF;
                    ref_clr = 1'b1;
                    cnt_d   = CNT_W'(RFC_p - 1);
                end else if (req_valid_i) begin
                    state_d = ACTIVATE;
                    cmd_d   = CMD_ACT;
                    ba_d    = req_addr_i[ADDR_W-1 -: BANK_W_p];
                    a_d     = req_addr_i[COL_W_p +: ROW_W_p];
                    col_d   = req_addr_i[COL_W_p-1:0];
                    we_d    = req_we_i;
                    cnt_d   = CNT_W'(RCD_p - 1);
                end
            end
            REFRESH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_dec;
            end
            ACTIVATE: begin
                if (cnt_q == '0) begin
                    a_d    = A10 | ROW_W_p'(col_q);
                    bcnt_d = BCNT_W'(BURST_p - 1);
                    if (we_q) begin
                        state_d = WRCMD;
                        cmd_d   = CMD_WR;
                        wr_take = 1'b1;
                        dq_d    = wr_data_i;
                        dq_oe_d = 1'b1;
                    end else begin
                        state_d = RDCMD;
                        cmd_d   = CMD_RD;
                        cnt_d   = CNT_W'(CAS_p + BURST_p - 1);
                    end
                end else cnt_d = cnt_dec;
            end
            // bcnt_q counts beats still to be fetched after the one on the bus.
            WRCMD: begin
                if (bcnt_q != '0) begin
                    wr_take = 1'b1;
                    dq_d    = wr_data_i;
                    bcnt_d  = bcnt_q - BCNT_W'(1);
                end else begin
                    state_d = RECOVER;
                    dq_oe_d = 1'b0;
                    cnt_d   = CNT_W'(WR_p + RP_p);
                end
            end
            // The last BURST_p counts of the wait are the capture window for dq_i.
            RDCMD: begin
                if (cnt_q < CNT_W'(BURST_p)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = dq_i;
                end
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(RP_p);
                end else cnt_d = cnt_dec;
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_dec;
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            iref_q      <= '0;
            bcnt_q      <= '0;
            col_q       <= '0;
            we_q        <= 1'b0;
            cmd_q       <= CMD_NOP;
            ba_q        <= '0;
            a_q         <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            cke_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iref_q      <= iref_d;
            bcnt_q      <= bcnt_d;
            col_q       <= col_d;
            we_q        <= we_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            a_q         <= a_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
            cke_q       <= 1'b1;
        end
    end

    // Expiry wins over a same-cycle clear so no refresh interval is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q         <= '0;
            ref_pending_q <= 1'b0;
        end else if (init_done_q) begin
            if (tmr_q == TMR_W'(REF_INT_p - 1)) begin
                tmr_q         <= '0;
                ref_pending_q <= 1'b1;
            end else begin
                tmr_q <= tmr_q + TMR_W'(1);
                if (ref_clr) ref_pending_q <= 1'b0;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE) && !ref_pending_q;
    assign wr_take_o   = wr_take;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign init_done_o = init_done_q;
    assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = cmd_q;
    assign cke_o       = cke_q;
    assign ba_o        = ba_q;
    assign a_o         = a_q;
    assign dq_o        = dq_q;
    assign dq_oe_o     = dq_oe_q;

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Directed bench: default-parameter controller for init/write/refresh/reset,
// a CAS-3 instance for read latency; beats checked through scoreboard queues.
module tb_sdram_ctrl_fsm;

    localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011, RD  = 4'b0101, WR  = 4'b0100;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_valid3 = 1'b0;
    logic        req_we_i = 1'b0;
    logic [23:0] req_addr_i = '0;
    logic [15:0] wr_data_i = '0;
    logic [15:0] dq_i = '0;

    logic        req_ready_o, wr_take_o, rd_valid_o, init_done_o;
    logic        cs_n_o, ras_n_o, cas_n_o, we_n_o, cke_o, dq_oe_o;
    logic [15:0] rd_data_o, dq_o;
    logic [1:0]  ba_o;
    logic [12:0] a_o;

    logic        ready3, take3, rv3, done3, cs3, ras3, cas3, we3, cke3, oe3;
    logic [15:0] rdd3, dqo3;
    logic [1:0]  ba3;
    logic [12:0] a3;

    logic [3:0] cmd, cmd3;
    assign cmd  = {cs_n_o, ras_n_o, cas_n_o, we_n_o};
    assign cmd3 = {cs3, ras3, cas3, we3};

    sdram_ctrl_fsm u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .wr_data_i(wr_data_i),
        .wr_take_o(wr_take_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .init_done_o(init_done_o), .cs_n_o(cs_n_o), .ras_n_o(ras_n_o), .cas_n_o(cas_n_o),
        .we_n_o(we_n_o), .cke_o(cke_o), .ba_o(ba_o), .a_o(a_o), .dq_o(dq_o),
        .dq_oe_o(dq_oe_o), .dq_i(dq_i)
    );

    sdram_ctrl_fsm #(.CAS_p(3)) u_cas3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid3), .req_ready_o(ready3),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .wr_data_i(wr_data_i),
        .wr_take_o(take3), .rd_data_o(rdd3), .rd_valid_o(rv3),
        .init_done_o(done3), .cs_n_o(cs3), .ras_n_o(ras3), .cas_n_o(cas3),
        .we_n_o(we3), .cke_o(cke3), .ba_o(ba3), .a_o(a3), .dq_o(dqo3),
        .dq_oe_o(oe3), .dq_i(dq_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int n_oe, n_take, n_rv, rv_first, rv_last, wi;
    int rd_cyc = -100;
    logic [15:0] beats[4];
    logic [15:0] wq[$];
    logic [15:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, check outgoing beats, then drive next inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (dq_oe_o) begin
            n_oe++;
            if (wq.size() == 0) chk("dq_unexpected_beat", 32'(dq_o), 32'hDEAD);
            else chk("dq_beat", 32'(dq_o), 32'(wq.pop_front()));
        end
        if (rv3) begin
            n_rv++;
            if (rv_first < 0) rv_first = cyc;
            rv_last = cyc;
            if (rq.size() == 0) chk("rd_unexpected_beat", 32'(rdd3), 32'hDEAD);
            else chk("rd_beat", 32'(rdd3), 32'(rq.pop_front()));
        end
        if (cmd3 == RD) rd_cyc = cyc;
        dq_i = 16'($urandom);
        if (cyc >= rd_cyc + 3 && cyc < rd_cyc + 7) rq.push_back(dq_i);
        if (wr_take_o) begin
            n_take++;
            if (wi < 4) begin
                wr_data_i = beats[wi];
                wq.push_back(beats[wi]);
                wi++;
            end
        end
    endtask

    task automatic init_check();
        logic [3:0] ec[3];
        int eo[3];
        int n, p, idx, dn;
        bit seen;
        ec = '{REF, REF, MRS};
        eo = '{2, 9, 16};
        n = 0; seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (cmd == NOP) n++;
            else seen = 1;
        end
        chk("pwrup_nops", 32'(n), 32'd100);
        chk("pre_cmd", 32'(cmd), 32'(PRE));
        chk("pre_a10", 32'(a_o[10]), 32'd1);
        p = cyc; idx = 0; dn = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cmd != NOP) begin
                if (idx < 3) begin
                    chk("init_cmd", 32'(cmd), 32'(ec[idx]));
                    chk("init_cmd_at", 32'(cyc - p), 32'(eo[idx]));
                    if (cmd == MRS) begin
                        chk("mrs_a", 32'(a_o), 32'h022);
                        chk("mrs_a_cas3", 32'(a3), 32'h032);
                    end
                end else chk("init_extra_cmd", 32'(cmd), 32'(NOP));
                idx++;
            end
            if (init_done_o && dn < 0) dn = cyc - p;
        end
        chk("init_cmd_count", 32'(idx), 32'd3);
        chk("init_done_at", 32'(dn), 32'd18);
    endtask

    initial begin
        int act_c, wr_c, last_c, rdy_c, ref_c;
        logic [3:0] first;
        bit done;
        wi = 4; n_oe = 0; n_take = 0; n_rv = 0; rv_first = -1; rv_last = -1;

        // Reset state
        for (int k = 0; k < 3; k++) tick();
        chk("rst_cmd", 32'(cmd), 32'(NOP));
        chk("rst_cke", 32'(cke_o), 32'd1);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_wr_take", 32'(wr_take_o), 32'd0);
        rst_ni = 1'b1;
        init_check();

        // Write bank 1 row 0x12 col 0x4
        beats = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        wi = 0; n_oe = 0; n_take = 0;
        req_we_i = 1'b1; req_addr_i = {2'd1, 13'h012, 9'h004}; req_valid_i = 1'b1;
        act_c = -1; wr_c = -1; last_c = -1; rdy_c = -1;
        for (int k = 0; k < 40 && rdy_c < 0; k++) begin
            tick();
            if (cmd == ACT && act_c < 0) begin
                act_c = cyc; req_valid_i = 1'b0;
                chk("act_ba", 32'(ba_o), 32'd1);
                chk("act_row", 32'(a_o), 32'h012);
            end
            if (cmd == WR) begin
                wr_c = cyc;
                chk("wr_a", 32'(a_o), 32'h404);
                chk("wr_ba", 32'(ba_o), 32'd1);
            end
            if (dq_oe_o) last_c = cyc;
            if (last_c >= 0 && !dq_oe_o && req_ready_o) rdy_c = cyc;
        end
        chk("act_to_wr", 32'(wr_c - act_c), 32'd2);
        chk("dq_oe_len", 32'(n_oe), 32'd4);
        chk("wr_take_len", 32'(n_take), 32'd4);
        chk("wr_beats_left", 32'(wq.size()), 32'd0);
        chk("ready_after_last_beat", 32'(rdy_c - last_c), 32'd6);

        // Read on the CAS-3 instance
        req_we_i = 1'b0; req_addr_i = {2'd2, 13'h1AB, 9'h01F}; req_valid3 = 1'b1;
        n_rv = 0; rv_first = -1; rd_cyc = -100;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cmd3 == ACT && req_valid3) begin
                req_valid3 = 1'b0;
                chk("rd_act_ba", 32'(ba3), 32'd2);
                chk("rd_act_row", 32'(a3), 32'h1AB);
            end
            if (cmd3 == RD) chk("rd_a", 32'(a3), 32'h41F);
        end
        chk("rd_valid_rise", 32'(rv_first - rd_cyc), 32'd4);
        chk("rd_valid_len", 32'(n_rv), 32'd4);
        chk("rd_valid_contig", 32'(rv_last - rv_first), 32'd3);
        chk("rd_beats_left", 32'(rq.size()), 32'd0);

        // Request colliding with a fresh refresh request in IDLE
        done = 0;
        for (int k = 0; k < 1200 && !done; k++) begin
            tick();
            if (!req_ready_o) done = 1;
        end
        chk("ref_pending_seen", 32'(done), 32'd1);
        req_we_i = 1'b0; req_valid_i = 1'b1;
        first = NOP; ref_c = -1; act_c = -1;
        for (int k = 0; k < 30 && act_c < 0; k++) begin
            tick();
            if (cmd != NOP && first == NOP) first = cmd;
            if (cmd == REF) ref_c = cyc;
            if (cmd == ACT) begin act_c = cyc; req_valid_i = 1'b0; end
        end
        chk("ref_before_act", 32'(first), 32'(REF));
        chk("act_after_ref", 32'(act_c - ref_c), 32'd8);
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (req_ready_o) done = 1;
        end
        chk("idle_after_read", 32'(done), 32'd1);

        // Reset pulsed during write beat 2
        beats = '{16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3};
        wi = 0; n_oe = 0;
        req_we_i = 1'b1; req_addr_i = {2'd3, 13'h0055, 9'h010}; req_valid_i = 1'b1;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (cmd == ACT) req_valid_i = 1'b0;
            if (n_oe == 3) done = 1;
        end
        chk("reached_beat2", 32'(done), 32'd1);
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("arst_dq_oe", 32'(dq_oe_o), 32'd0);
        chk("arst_init_done", 32'(init_done_o), 32'd0);
        chk("arst_cmd", 32'(cmd), 32'(NOP));
        chk("arst_ready", 32'(req_ready_o), 32'd0);
        chk("arst_wr_take", 32'(wr_take_o), 32'd0);
        chk("arst_cke", 32'(cke_o), 32'd1);
        wq.delete();
        wi = 4;
        tick();
        rst_ni = 1'b1;
        init_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
